juntador_16_32: RTL and testbench
=================================

# juntador_16_32

Reassembles 32-bit words from a stream of 16-bit halfwords. It is the inverse of the 32→16 halfword splitter on the Nios software datapath. Each word is built from two consecutive accepted halfwords and tagged with one of two destinations (0 or 1). Completed words are presented on a registered valid/ready output, and the block keeps per-destination word counts and a sticky error flag for halfword pairs whose destinations do not match.

## Interface
Parameters:
- PRIMEIRO_ALTO, 1: 1 = first halfword of a pair is bits [31:16]; 0 = first is bits [15:0].
- LARGURA_CONT, 8: width of the per-destination word counters.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; one cycle of reset=1 at a rising edge restores the reset state.
- dado_16  in  16  input halfword.
- valido_16  in  1  dado_16/destino_16 valid.
- destino_16  in  1  destination tag of the halfword (0 or 1).
- pronto_16  out  1  block can accept a halfword this cycle.
- limpar  in  1  discard a partially assembled word.
- saida_32  out  32  assembled word.
- destino_32  out  1  destination of saida_32.
- valido_32  out  1  saida_32 valid.
- pronto_32  in  1  downstream accepts saida_32.
- cont_0  out  LARGURA_CONT  words delivered to destination 0.
- cont_1  out  LARGURA_CONT  words delivered to destination 1.
- erro_destino  out  1  sticky: a pair had mismatched destino_16.

## Operation
- Handshakes:
  - Input transfer = valido_16 & pronto_16 at a rising edge.
  - Output transfer = valido_32 & pronto_32 at a rising edge.
- FSM states: VAZIO, MEIO, CHEIO.
- VAZIO:
  - pronto_16=1, valido_32=0.
  - On input transfer: store dado_16 in the first-half register and latch destino_16 → MEIO.
- MEIO:
  - pronto_16=1, valido_32=0.
  - On input transfer: place the stored first half and the new dado_16 according to PRIMEIRO_ALTO.
    - PRIMEIRO_ALTO=1: saida_32 = {first, second}.
    - PRIMEIRO_ALTO=0: saida_32 = {second, first}.
  - destino_32 = destino latched from the first halfword → CHEIO.
  - If the second halfword's destino_16 differs from the latched one: set erro_destino=1; the word is still delivered with the first halfword's destination.
- CHEIO:
  - pronto_16=0, valido_32=1.
  - saida_32/destino_32 held stable until the output transfer.
  - On output transfer: increment cont_0 or cont_1 per destino_32 → VAZIO.
- Counters wrap modulo 2^LARGURA_CONT with no saturation and no flag.
- limpar:
  - In MEIO: discards the stored half → VAZIO. An input transfer in the same cycle is ignored, and pronto_16 is still 1.
  - In VAZIO or CHEIO: no effect; a completed word is never discarded.
- erro_destino is cleared only by reset.
- Reset values: state VAZIO, pronto_16=1, valido_32=0, saida_32=0, destino_32=0, cont_0=0, cont_1=0, erro_destino=0.
- Reset mid-operation: a partial half or a pending output word is lost; no counter increments.
- Reset has priority over limpar, and limpar has priority over input transfers.

## Timing
- All outputs are registered except pronto_16, which is decoded from the state register only. There is no combinational path from valido_16 or pronto_32.
- Latency: second halfword accepted at edge N → valido_32=1 from edge N (visible in cycle N+1).
- Peak throughput: 1 word per 3 cycles (2 input transfers + 1 output transfer).
- Output stall: in CHEIO with pronto_32=0, the block holds indefinitely, pronto_16 stays 0, and the counters do not change.
- valido_16=1 while pronto_16=0 is legal. The halfword is not consumed, and the source must hold it.
- Counter update and state → VAZIO occur on the same edge as the output transfer.

## Test plan
- Basic pair, PRIMEIRO_ALTO=1:
  - Stimulus: halfwords 16'hABCD then 16'h1234, both destino 0, pronto_32=1.
  - Response: saida_32=32'hABCD1234, destino_32=0, valido_32 for exactly 1 cycle, cont_0=1.
- Order parameter, PRIMEIRO_ALTO=0:
  - Stimulus: same stimulus with destino 1.
  - Response: saida_32=32'h1234ABCD, cont_1=1, cont_0=0.
- Backpressure:
  - Stimulus: pronto_32=0 for 5 cycles after the word completes, with valido_16 held at 1.
  - Response: saida_32 stable, pronto_16=0 and no halfword consumed throughout; after pronto_32=1, the next pair is accepted and delivered correctly.
- Mismatch:
  - Stimulus: first halfword destino 1, second halfword destino 0.
  - Response: word delivered with destino_32=1, erro_destino=1 and remaining 1 after later good pairs until reset.
- limpar in MEIO:
  - Stimulus: 16'h1111 accepted, then limpar=1 while 16'h2222 is offered, then 16'h3333 and 16'h4444 follow.
  - Response: only 32'h33334444 is delivered; 16'h2222 is not consumed.
- Reset and wrap:
  - Stimulus: with LARGURA_CONT=2, deliver 5 words to destination 0; then reset while in MEIO.
  - Response: cont_0 reads 1 after the fifth word; after reset, all outputs are at their reset values and no word is emitted.

Source files
------------

// File: rtl/juntador_16_32_if.sv
// Halfword-in / word-out stream bundle for juntador_16_32.
// master = halfword source and word sink; slave = the reassembler.
interface juntador_16_32_if;
  logic [15:0] dado_16;
  logic        valido_16;
  logic        destino_16;
  logic        pronto_16;
  logic        limpar;
  logic [31:0] saida_32;
  logic        destino_32;
  logic        valido_32;
  logic        pronto_32;

  modport master (
    output dado_16, valido_16, destino_16, limpar, pronto_32,
    input  pronto_16, saida_32, destino_32, valido_32
  );

  modport slave (
    input  dado_16, valido_16, destino_16, limpar, pronto_32,
    output pronto_16, saida_32, destino_32, valido_32
  );
endinterface

// File: rtl/juntador_16_32.sv
// Joins pairs of 16-bit halfwords into tagged 32-bit words, with
// per-destination delivery counters and a sticky destination-mismatch flag.
module juntador_16_32 #(
  parameter int PRIMEIRO_ALTO = 1,
  parameter int LARGURA_CONT  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  juntador_16_32_if.slave         bus,
  output logic [LARGURA_CONT-1:0] cont_0,
  output logic [LARGURA_CONT-1:0] cont_1,
  output logic                    erro_destino
);

  typedef enum logic [1:0] {VAZIO, MEIO, CHEIO} estado_t;

  estado_t     estado;
  logic [15:0] primeiro;
  logic        destino_primeiro;
  logic [31:0] saida_q;
  logic        destino_q;
  logic        valido_q;

  // Ready depends on state alone, so upstream sees no path from our inputs.
  assign bus.pronto_16  = (estado != CHEIO);
  assign bus.saida_32   = saida_q;
  assign bus.destino_32 = destino_q;
  assign bus.valido_32  = valido_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      estado           <= VAZIO;
      primeiro         <= '0;
      destino_primeiro <= 1'b0;
      saida_q          <= '0;
      destino_q        <= 1'b0;
      valido_q         <= 1'b0;
      cont_0           <= '0;
      cont_1           <= '0;
      erro_destino     <= 1'b0;
    end else begin
      case (estado)
        VAZIO: begin
          if (bus.valido_16) begin
            primeiro         <= bus.dado_16;
            destino_primeiro <= bus.destino_16;
            estado           <= MEIO;
          end
        end
        MEIO: begin
          // limpar wins over a halfword offered in the same cycle.
          if (bus.limpar) begin
            estado <= VAZIO;
          end else if (bus.valido_16) begin
            saida_q   <= (PRIMEIRO_ALTO != 0) ? {primeiro, bus.dado_16}
                                              : {bus.dado_16, primeiro};
            destino_q <= destino_primeiro;
            valido_q  <= 1'b1;
            if (bus.destino_16 != destino_primeiro)
              erro_destino <= 1'b1;
            estado <= CHEIO;
          end
        end
        CHEIO: begin
          if (bus.pronto_32) begin
            valido_q <= 1'b0;
            if (destino_q) cont_1 <= cont_1 + 1'b1;
            else           cont_0 <= cont_0 + 1'b1;
            estado <= VAZIO;
          end
        end
        default: begin
          valido_q <= 1'b0;
          estado   <= VAZIO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_juntador_16_32.sv
// Drives two reassemblers (high-first with 2-bit counters, low-first with
// 8-bit counters) from one stimulus stream and checks them against a pairing model.
module tb_juntador_16_32;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic [15:0] dado = '0;
  logic        val16 = 1'b0, dst16 = 1'b0, limpar = 1'b0, pr32 = 1'b0;

  juntador_16_32_if ia ();
  juntador_16_32_if ib ();
  assign ia.dado_16 = dado;  assign ib.dado_16 = dado;
  assign ia.valido_16 = val16; assign ib.valido_16 = val16;
  assign ia.destino_16 = dst16; assign ib.destino_16 = dst16;
  assign ia.limpar = limpar; assign ib.limpar = limpar;
  assign ia.pronto_32 = pr32; assign ib.pronto_32 = pr32;

  logic [1:0] a_c0, a_c1;
  logic [7:0] b_c0, b_c1;
  logic       a_err, b_err;

  juntador_16_32 #(.PRIMEIRO_ALTO(1), .LARGURA_CONT(2)) u_a (
    .clk(clk), .reset(rst), .bus(ia.slave),
    .cont_0(a_c0), .cont_1(a_c1), .erro_destino(a_err));
  juntador_16_32 #(.PRIMEIRO_ALTO(0), .LARGURA_CONT(8)) u_b (
    .clk(clk), .reset(rst), .bus(ib.slave),
    .cont_0(b_c0), .cont_1(b_c1), .erro_destino(b_err));

  int total = 0;
  int bad = 0;

  // Reference: a held first half, an optional finished word, counts as plain integers.
  bit          m_part, m_full, m_fdest, m_dest, m_err;
  logic [15:0] m_first;
  logic [31:0] m_wa, m_wb;
  int          m_c0, m_c1;

  task automatic model_edge();
    if (rst) begin
      m_part = 0; m_full = 0; m_dest = 0; m_err = 0;
      m_wa = '0; m_wb = '0; m_c0 = 0; m_c1 = 0;
    end else if (m_full) begin
      if (pr32) begin
        if (m_dest) m_c1++; else m_c0++;
        m_full = 0;
      end
    end else if (m_part && limpar) begin
      m_part = 0;
    end else if (val16) begin
      if (!m_part) begin
        m_first = dado; m_fdest = dst16; m_part = 1;
      end else begin
        m_wa = {m_first, dado}; m_wb = {dado, m_first};
        m_dest = m_fdest;
        if (dst16 != m_fdest) m_err = 1;
        m_full = 1; m_part = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic send_half(input logic [15:0] d, input logic t);
    dado = d; dst16 = t; val16 = 1'b1;
    tick();
    val16 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    val16 = 0; limpar = 0; pr32 = 0;
    do_reset();
    total++; if (ia.pronto_16 !== 1'b1 || ib.pronto_16 !== 1'b1) begin bad++; $display("FAIL reset_pronto16 got=%b/%b exp=1", ia.pronto_16, ib.pronto_16); end
    total++; if (ia.valido_32 !== 1'b0 || ib.valido_32 !== 1'b0) begin bad++; $display("FAIL reset_valido32 got=%b/%b exp=0", ia.valido_32, ib.valido_32); end
    total++; if (ia.saida_32 !== 32'h0 || ib.saida_32 !== 32'h0 || ia.destino_32 !== 1'b0 || ib.destino_32 !== 1'b0) begin bad++; $display("FAIL reset_saida got=%h/%h exp=0", ia.saida_32, ib.saida_32); end
    total++; if (a_c0 !== 2'd0 || a_c1 !== 2'd0 || b_c0 !== 8'd0 || b_c1 !== 8'd0 || a_err !== 1'b0 || b_err !== 1'b0) begin bad++; $display("FAIL reset_cont got=%0d %0d %0d %0d err=%b%b exp=0", a_c0, a_c1, b_c0, b_c1, a_err, b_err); end
  endtask

  task automatic test_basic();
    do_reset(); pr32 = 1;
    send_half(16'hABCD, 0);
    total++; if (ia.valido_32 !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b exp=0", ia.valido_32); end
    send_half(16'h1234, 0);
    total++; if (ia.valido_32 !== 1'b1 || ia.saida_32 !== 32'hABCD1234 || ia.destino_32 !== 1'b0) begin bad++; $display("FAIL basic_word_alto got=%b %h %b exp=1 abcd1234 0", ia.valido_32, ia.saida_32, ia.destino_32); end
    total++; if (ib.saida_32 !== 32'h1234ABCD) begin bad++; $display("FAIL basic_word_baixo got=%h exp=1234abcd", ib.saida_32); end
    tick();
    total++; if (ia.valido_32 !== 1'b0 || ib.valido_32 !== 1'b0) begin bad++; $display("FAIL basic_one_cycle got=%b/%b exp=0", ia.valido_32, ib.valido_32); end
    total++; if (a_c0 !== 2'd1 || b_c0 !== 8'd1 || b_c1 !== 8'd0) begin bad++; $display("FAIL basic_cont got=%0d %0d %0d exp=1 1 0", a_c0, b_c0, b_c1); end
  endtask

  task automatic test_order();
    do_reset(); pr32 = 1;
    send_half(16'hABCD, 1);
    send_half(16'h1234, 1);
    total++; if (ib.saida_32 !== 32'h1234ABCD || ib.destino_32 !== 1'b1) begin bad++; $display("FAIL order_baixo got=%h %b exp=1234abcd 1", ib.saida_32, ib.destino_32); end
    total++; if (ia.saida_32 !== 32'hABCD1234 || ia.destino_32 !== 1'b1) begin bad++; $display("FAIL order_alto got=%h %b exp=abcd1234 1", ia.saida_32, ia.destino_32); end
    tick();
    total++; if (b_c1 !== 8'd1 || b_c0 !== 8'd0 || a_c1 !== 2'd1 || a_c0 !== 2'd0) begin bad++; $display("FAIL order_cont got=%0d %0d %0d %0d exp=1 0 1 0", b_c1, b_c0, a_c1, a_c0); end
  endtask

  task automatic test_backpressure();
    do_reset(); pr32 = 0;
    send_half(16'h5555, 0);
    send_half(16'h6666, 0);
    dado = 16'h7777; dst16 = 0; val16 = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (ia.pronto_16 !== 1'b0 || ia.valido_32 !== 1'b1 || ia.saida_32 !== 32'h55556666 || ib.saida_32 !== 32'h66665555) begin bad++; $display("FAIL stall_hold c%0d got=%b %b %h %h", i, ia.pronto_16, ia.valido_32, ia.saida_32, ib.saida_32); end
      total++; if (a_c0 !== 2'd0 || b_c0 !== 8'd0) begin bad++; $display("FAIL stall_cont c%0d got=%0d %0d exp=0", i, a_c0, b_c0); end
    end
    pr32 = 1;
    tick();
    total++; if (ia.pronto_16 !== 1'b1 || ia.valido_32 !== 1'b0 || a_c0 !== 2'd1) begin bad++; $display("FAIL stall_release got=%b %b %0d exp=1 0 1", ia.pronto_16, ia.valido_32, a_c0); end
    tick();
    send_half(16'h8888, 0);
    total++; if (ia.saida_32 !== 32'h77778888 || ib.saida_32 !== 32'h88887777 || ia.valido_32 !== 1'b1) begin bad++; $display("FAIL stall_next got=%h %h exp=77778888 88887777", ia.saida_32, ib.saida_32); end
    tick();
    total++; if (a_c0 !== 2'd2 || b_c0 !== 8'd2) begin bad++; $display("FAIL stall_next_cont got=%0d %0d exp=2", a_c0, b_c0); end
  endtask

  task automatic test_mismatch();
    do_reset(); pr32 = 1;
    send_half(16'hA001, 1);
    send_half(16'hB002, 0);
    total++; if (ia.destino_32 !== 1'b1 || a_err !== 1'b1 || b_err !== 1'b1) begin bad++; $display("FAIL mismatch_flag got=%b %b %b exp=1 1 1", ia.destino_32, a_err, b_err); end
    tick();
    send_half(16'hC003, 0);
    send_half(16'hD004, 0);
    tick();
    total++; if (a_err !== 1'b1 || b_err !== 1'b1 || b_c1 !== 8'd1 || b_c0 !== 8'd1) begin bad++; $display("FAIL mismatch_sticky got=%b %b %0d %0d exp=1 1 1 1", a_err, b_err, b_c1, b_c0); end
  endtask

  task automatic test_limpar();
    do_reset(); pr32 = 1;
    send_half(16'h1111, 0);
    dado = 16'h2222; val16 = 1; limpar = 1;
    total++; if (ia.pronto_16 !== 1'b1) begin bad++; $display("FAIL limpar_pronto got=%b exp=1", ia.pronto_16); end
    tick();
    val16 = 0; limpar = 0;
    total++; if (ia.valido_32 !== 1'b0 || ib.valido_32 !== 1'b0) begin bad++; $display("FAIL limpar_no_word got=%b exp=0", ia.valido_32); end
    send_half(16'h3333, 0);
    send_half(16'h4444, 0);
    total++; if (ia.saida_32 !== 32'h33334444 || ib.saida_32 !== 32'h44443333) begin bad++; $display("FAIL limpar_word got=%h %h exp=33334444 44443333", ia.saida_32, ib.saida_32); end
    tick();
    pr32 = 0;
    send_half(16'h5151, 0);
    send_half(16'h6161, 0);
    limpar = 1; tick(); limpar = 0;
    total++; if (ia.valido_32 !== 1'b1 || ia.saida_32 !== 32'h51516161) begin bad++; $display("FAIL limpar_cheio got=%b %h exp=1 51516161", ia.valido_32, ia.saida_32); end
    pr32 = 1; tick();
    total++; if (a_c0 !== 2'd2 || b_c0 !== 8'd2) begin bad++; $display("FAIL limpar_cont got=%0d %0d exp=2", a_c0, b_c0); end
  endtask

  task automatic test_wrap_reset();
    do_reset(); pr32 = 1;
    for (int i = 0; i < 5; i++) begin
      send_half(16'(i), 0);
      send_half(16'(i + 16), 0);
      tick();
    end
    total++; if (a_c0 !== 2'd1) begin bad++; $display("FAIL wrap_cont2 got=%0d exp=1", a_c0); end
    total++; if (b_c0 !== 8'd5) begin bad++; $display("FAIL wrap_cont8 got=%0d exp=5", b_c0); end
    send_half(16'h9999, 0);
    rst = 1; dado = 16'hAAAA; val16 = 1; tick(); rst = 0;
    val16 = 0;
    total++; if (ia.valido_32 !== 1'b0 || ia.pronto_16 !== 1'b1 || ia.saida_32 !== 32'h0 || a_c0 !== 2'd0 || b_c0 !== 8'd0) begin bad++; $display("FAIL midreset got=%b %b %h %0d %0d", ia.valido_32, ia.pronto_16, ia.saida_32, a_c0, b_c0); end
    send_half(16'hBBBB, 0);
    tick();
    total++; if (ia.valido_32 !== 1'b0 || ib.valido_32 !== 1'b0) begin bad++; $display("FAIL midreset_no_word got=%b/%b exp=0", ia.valido_32, ib.valido_32); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst    = ($urandom_range(0, 79) == 0);
      dado   = 16'($urandom);
      val16  = ($urandom_range(0, 9) < 7);
      dst16  = ($urandom_range(0, 5) == 0) ? 1'($urandom) : 1'(c / 40);
      limpar = ($urandom_range(0, 7) == 0);
      pr32   = ($urandom_range(0, 9) < 6);
      tick();
      total++; if (ia.pronto_16 !== !m_full || ib.pronto_16 !== !m_full || ia.valido_32 !== m_full || ib.valido_32 !== m_full) begin bad++; $display("FAIL rnd_hs c%0d got=%b%b%b%b exp_full=%b", c, ia.pronto_16, ib.pronto_16, ia.valido_32, ib.valido_32, m_full); end
      if (m_full) begin
        total++; if (ia.saida_32 !== m_wa || ib.saida_32 !== m_wb || ia.destino_32 !== m_dest || ib.destino_32 !== m_dest) begin bad++; $display("FAIL rnd_word c%0d got=%h %h %b exp=%h %h %b", c, ia.saida_32, ib.saida_32, ia.destino_32, m_wa, m_wb, m_dest); end
      end
      total++; if (a_c0 !== 2'(m_c0 % 4) || a_c1 !== 2'(m_c1 % 4) || b_c0 !== 8'(m_c0 % 256) || b_c1 !== 8'(m_c1 % 256)) begin bad++; $display("FAIL rnd_cont c%0d got=%0d %0d %0d %0d exp=%0d %0d", c, a_c0, a_c1, b_c0, b_c1, m_c0, m_c1); end
      total++; if (a_err !== m_err || b_err !== m_err) begin bad++; $display("FAIL rnd_err c%0d got=%b %b exp=%b", c, a_err, b_err, m_err); end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_order();
    test_backpressure();
    test_mismatch();
    test_limpar();
    test_wrap_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
